// File: rtl/had_segment_reduce.sv
// Segment reducer: streams NUM_WORDS products from BRAM, FP32-sums each run of SEG_WORDS
// and writes one sum per segment. Optional grand-total write via REDUCE_GRAND_TOTAL_EN.
module had_segment_reduce #(
   parameter int FP_WIDTH   = 32,
   parameter int BRAM_WIDTH = 32,
   parameter int WORD_BYTES = 4,
   parameter int ADDR_WIDTH = 12,
   parameter int NUM_WORDS  = 512,
   parameter int SEG_WORDS  = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [31:0]           ps_control,
   output logic [31:0]           pl_status,
   output logic [ADDR_WIDTH-1:0] bram_addr_product,
   input  logic [BRAM_WIDTH-1:0] bram_rddata_product,
   output logic [ADDR_WIDTH-1:0] bram_addr_sum,
   output logic [BRAM_WIDTH-1:0] bram_wrdata_sum,
   output logic [WORD_BYTES-1:0] bram_we_sum
);
   localparam int PW = (SEG_WORDS > 1) ? $clog2(SEG_WORDS) : 1;
   localparam logic [ADDR_WIDTH-1:0] WB   = ADDR_WIDTH'(WORD_BYTES);
   localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'((NUM_WORDS-1)*WORD_BYTES);
   localparam logic [PW-1:0]         PLST = PW'(SEG_WORDS-1);

   typedef enum logic [2:0] {S_IDLE, S_RUN, S_DRAIN, S_TOTAL, S_DONE} st_t;

   // Round-to-nearest-even single-precision add; subnormals kept, NaN results are quiet NaN.
   function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
      logic [31:0] x, y;
      logic [9:0]  ex, ey, e, dd;
      logic [7:0]  d;
      logic [26:0] mx, my, m, mask;
      logic [27:0] s;
      logic [24:0] r;
      logic        up;
      if (a[30:0] >= b[30:0]) begin x = a; y = b; end
      else begin x = b; y = a; end
      if (x[30:23] == 8'hFF) begin
         if (x[22:0] != 23'd0) return 32'h7FC00000;
         if (y[30:23] == 8'hFF && x[31] != y[31]) return 32'h7FC00000;
         return x;
      end
      ex = (x[30:23] == 8'd0) ? 10'd1 : {2'b00, x[30:23]};
      ey = (y[30:23] == 8'd0) ? 10'd1 : {2'b00, y[30:23]};
      mx = {x[30:23] != 8'd0, x[22:0], 3'b000};
      my = {y[30:23] != 8'd0, y[22:0], 3'b000};
      dd = ex - ey;
      d  = (dd > 10'd27) ? 8'd27 : dd[7:0];
      mask = ~(27'h7FFFFFF << d);
      my = (my >> d) | {26'd0, |(my & mask)};
      e  = ex;
      if (x[31] == y[31]) begin
         s = {1'b0, mx} + {1'b0, my};
         if (s[27]) begin m = {s[27:2], s[1] | s[0]}; e = e + 10'd1; end
         else m = s[26:0];
      end else begin
         m = mx - my;
         if (m == 27'd0) return 32'h0;
         for (int i = 0; i < 26; i++)
            if (!m[26] && e > 10'd1) begin m = m << 1; e = e - 10'd1; end
      end
      up = m[2] & (m[1] | m[0] | m[3]);
      r  = {1'b0, m[26:3]} + {24'd0, up};
      if (r[24]) begin r = r >> 1; e = e + 10'd1; end
      if (e >= 10'd255) return {x[31], 8'hFF, 23'd0};
      return {x[31], (r[23] ? e[7:0] : 8'h00), r[22:0]};
   endfunction

   st_t                  state_q;
   logic [ADDR_WIDTH-1:0] rd_addr_q, seg_addr_q;
   logic [PW-1:0]         rd_pos_q, pos_q;
   logic                  vld_q;
   logic [FP_WIDTH-1:0]   acc_q, total_q, sum_d;
   logic                  start, seg_wr, tot_wr, we;
   logic                  unused_ctl;

   assign start      = ps_control[0];
   assign unused_ctl = ^ps_control[31:1];

   // pos_q is the in-segment position of the word arriving this cycle
   assign sum_d  = (pos_q == '0) ? bram_rddata_product : fp_add(acc_q, bram_rddata_product);
   assign seg_wr = vld_q && (pos_q == PLST);
`ifdef REDUCE_GRAND_TOTAL_EN
   assign tot_wr = (state_q == S_TOTAL);
`else
   assign tot_wr = 1'b0;
`endif
   // Gated by reset so a reset landing on a segment end emits no write
   assign we = (seg_wr || tot_wr) && !reset;

   assign bram_we_sum       = we ? {WORD_BYTES{1'b1}} : '0;
   assign bram_addr_sum     = we ? seg_addr_q : '0;
   assign bram_wrdata_sum   = !we ? '0 : seg_wr ? sum_d : total_q;
   assign bram_addr_product = rd_addr_q;
   assign pl_status = {30'd0,
                       state_q == S_RUN || state_q == S_DRAIN || state_q == S_TOTAL,
                       state_q == S_DONE};

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= S_IDLE;
         rd_addr_q  <= '0;
         rd_pos_q   <= '0;
         pos_q      <= '0;
         vld_q      <= 1'b0;
         seg_addr_q <= '0;
         acc_q      <= '0;
         total_q    <= '0;
      end else begin
         vld_q <= (state_q == S_RUN);
         pos_q <= rd_pos_q;
         if (vld_q) acc_q <= sum_d;
         if (seg_wr) begin
            seg_addr_q <= seg_addr_q + WB;
            total_q    <= fp_add(total_q, sum_d);
         end
         case (state_q)
            S_IDLE: begin
               rd_addr_q  <= '0;
               rd_pos_q   <= '0;
               seg_addr_q <= '0;
               total_q    <= '0;
               if (start) state_q <= S_RUN;
            end
            S_RUN: begin
               rd_addr_q <= rd_addr_q + WB;
               rd_pos_q  <= (rd_pos_q == PLST) ? '0 : rd_pos_q + PW'(1);
               if (rd_addr_q == LAST) begin
                  rd_addr_q <= '0;
                  state_q   <= S_DRAIN;
               end
            end
`ifdef REDUCE_GRAND_TOTAL_EN
            S_DRAIN: state_q <= S_TOTAL;
            S_TOTAL: state_q <= S_DONE;
`else
            S_DRAIN: state_q <= S_DONE;
`endif
            S_DONE:  if (!start) state_q <= S_IDLE;
            default: state_q <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_had_segment_reduce.sv
// Directed bench for had_segment_reduce: one SEG_WORDS=16 instance and one SEG_WORDS=1 instance.
module tb_had_segment_reduce;
   localparam int NW = 512;
`ifdef REDUCE_GRAND_TOTAL_EN
   localparam int XTRA = 1;
`else
   localparam int XTRA = 0;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] ctl_a, st_a, rd_a, wd_a, ctl_b, st_b, rd_b, wd_b;
   logic [11:0] ap_a, as_a, ap_b, as_b, prev_ap_b;
   logic [3:0]  we_a, we_b;
   logic [31:0] prod_a [NW];
   logic [31:0] prod_b [NW];
   logic [31:0] sum_a  [1024];
   logic [31:0] sum_b  [1024];
   int n_cmp = 0, n_bad = 0;
   int wr_a = 0, ord_a = 0, wr_b = 0, ord_b = 0, lag_b = 0;

   always #5 clk = ~clk;

   had_segment_reduce #(.SEG_WORDS(16)) dut_a (
      .clk(clk), .reset(reset), .ps_control(ctl_a), .pl_status(st_a),
      .bram_addr_product(ap_a), .bram_rddata_product(rd_a),
      .bram_addr_sum(as_a), .bram_wrdata_sum(wd_a), .bram_we_sum(we_a));

   had_segment_reduce #(.SEG_WORDS(1)) dut_b (
      .clk(clk), .reset(reset), .ps_control(ctl_b), .pl_status(st_b),
      .bram_addr_product(ap_b), .bram_rddata_product(rd_b),
      .bram_addr_sum(as_b), .bram_wrdata_sum(wd_b), .bram_we_sum(we_b));

   always @(posedge clk) begin
      rd_a <= prod_a[ap_a[10:2]];
      rd_b <= prod_b[ap_b[10:2]];
   end

   // Write monitor: records sums, checks strict address order and read-to-write lag
   always @(negedge clk) begin
      if (we_a != 4'd0) begin
         if (we_a != 4'hF || as_a != 12'(wr_a*4)) ord_a++;
         sum_a[as_a[11:2]] = wd_a;
         wr_a++;
      end
      if (we_b != 4'd0) begin
         if (we_b != 4'hF || as_b != 12'(wr_b*4)) ord_b++;
         if (as_b < 12'(NW*4) && as_b != prev_ap_b) lag_b++;
         sum_b[as_b[11:2]] = wd_b;
         wr_b++;
      end
      prev_ap_b = ap_b;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] i2f(input int v);
      int p;
      logic [31:0] u;
      if (v == 0) return 32'h0;
      u = v;
      p = 0;
      for (int i = 0; i < 24; i++) if (u[i]) p = i;
      u = u << (23 - p);
      return {1'b0, 8'(127 + p), u[22:0]};
   endfunction

   // Start a pass on dut_a; returns the cycle at which done was first seen (-1 on timeout)
   task automatic run_a(input int drop_at, output int done_cyc);
      int n;
      wr_a = 0; ord_a = 0;
      for (int i = 0; i < 1024; i++) sum_a[i] = 32'hDEADBEEF;
      @(negedge clk);
      ctl_a = 1;
      n = 0;
      done_cyc = -1;
      while (n < 1500) begin
         @(negedge clk);
         n++;
         if (n == 1) chk("busy_c1", st_a, 32'd2);
         if (st_a[0]) begin done_cyc = n; break; end
         if (n == drop_at) ctl_a = 0;
      end
   endtask

   initial begin
      int dc, n, bad;
      reset = 1; ctl_a = 0; ctl_b = 0;
      repeat (3) @(negedge clk);
      chk("rst_status", st_a, 32'd0);
      chk("rst_we", {28'd0, we_a}, 32'd0);
      chk("rst_addr_p", {20'd0, ap_a}, 32'd0);
      chk("rst_addr_s", {20'd0, as_a}, 32'd0);
      chk("rst_wdata", wd_a, 32'd0);
      reset = 0;

      // all-ones input, start held high past completion
      for (int i = 0; i < NW; i++) prod_a[i] = 32'h3F800000;
      run_a(0, dc);
      chk("ones_done_cyc", dc, 514 + XTRA);
      chk("ones_wr_cnt", wr_a, 32 + XTRA);
      chk("ones_order", ord_a, 0);
      bad = 0;
      for (int k = 0; k < 32; k++) if (sum_a[k] !== 32'h41800000) bad++;
      chk("ones_sum_bad", bad, 0);
      chk("ones_sum31", sum_a[31], 32'h41800000);
`ifdef REDUCE_GRAND_TOTAL_EN
      chk("ones_total", sum_a[32], 32'h44000000);
`endif
      repeat (6) @(negedge clk);
      chk("hold_done", st_a, 32'd1);
      chk("hold_no_restart", wr_a, 32 + XTRA);
      ctl_a = 0;
      @(negedge clk);
      chk("drop_idle", st_a, 32'd0);

      // ramp input, start dropped mid-RUN
      for (int i = 0; i < NW; i++) prod_a[i] = i2f(i);
      run_a(100, dc);
      chk("ramp_done_cyc", dc, 514 + XTRA);
      @(negedge clk);
      chk("ramp_done_exit", st_a, 32'd0);
      chk("ramp_wr_cnt", wr_a, 32 + XTRA);
      chk("ramp_order", ord_a, 0);
      chk("ramp_seg0", sum_a[0], 32'h42F00000);
      for (int k = 0; k < 32; k++) chk($sformatf("ramp_seg%0d", k), sum_a[k], i2f(256*k + 120));
`ifdef REDUCE_GRAND_TOTAL_EN
      chk("ramp_total", sum_a[32], i2f(130816));
`endif

      // reset in the middle of RUN, then a fresh pass
      @(negedge clk);
      ctl_a = 1;
      repeat (200) @(negedge clk);
      chk("mid_busy", st_a, 32'd2);
      reset = 1;
      #1 chk("rst_cycle_we", {28'd0, we_a}, 32'd0);
      @(negedge clk);
      chk("midrst_we", {28'd0, we_a}, 32'd0);
      chk("midrst_status", st_a, 32'd0);
      chk("midrst_addr_p", {20'd0, ap_a}, 32'd0);
      reset = 0; ctl_a = 0;
      @(negedge clk);
      run_a(0, dc);
      ctl_a = 0;
      chk("fresh_done_cyc", dc, 514 + XTRA);
      chk("fresh_wr_cnt", wr_a, 32 + XTRA);
      bad = 0;
      for (int k = 0; k < 32; k++) if (sum_a[k] !== i2f(256*k + 120)) bad++;
      chk("fresh_sum_bad", bad, 0);
      chk("fresh_seg0", sum_a[0], 32'h42F00000);

      // SEG_WORDS=1 passthrough
      for (int i = 0; i < NW; i++) prod_b[i] = $urandom;
      wr_b = 0; ord_b = 0; lag_b = 0;
      @(negedge clk);
      ctl_b = 1;
      n = 0; dc = -1;
      while (n < 1500) begin
         @(negedge clk);
         n++;
         if (st_b[0]) begin dc = n; break; end
      end
      ctl_b = 0;
      chk("pass_done_cyc", dc, 514 + XTRA);
      chk("pass_wr_cnt", wr_b, 512 + XTRA);
      chk("pass_order", ord_b, 0);
      chk("pass_lag", lag_b, 0);
      bad = 0;
      for (int i = 0; i < NW; i++) if (sum_b[i] !== prod_b[i]) bad++;
      chk("pass_data_bad", bad, 0);
      chk("pass_word7", sum_b[7], prod_b[7]);

      repeat (3) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
